// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : pipe_hazard_ctrl_pkg
// Brief  : Shared Y86-64 encodings and core run-state type for the control unit.
// Rev    : 1.0
// ============================================================================
package pipe_hazard_ctrl_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RNONE   = 4'hF;

    localparam logic [2:0] SAOK    = 3'd1;
    localparam logic [2:0] SADR    = 3'd2;
    localparam logic [2:0] SINS    = 3'd3;
    localparam logic [2:0] SHLT    = 3'd4;

    typedef enum logic [1:0] {
        CPU_RUN   = 2'd0,
        CPU_DRAIN = 2'd1,
        CPU_HALT  = 2'd2
    } cpu_state_e;

    function automatic logic is_mem_op(input logic [3:0] icode);
        logic r;
        r = 1'b0;
        case (icode)
            IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ: r = 1'b1;
            default:                                      r = 1'b0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : pipe_hazard_ctrl_if
// Brief  : Pipeline status inputs and stall/bubble/status outputs of the control unit.
// Rev    : 1.0
// ============================================================================
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [3:0]       D_icode_i;
    logic [3:0]       E_icode_i;
    logic [3:0]       M_icode_i;
    logic [3:0]       E_dstM_i;
    logic [3:0]       d_srcA_i;
    logic [3:0]       d_srcB_i;
    logic             e_Cnd_i;
    logic [2:0]       m_stat_i;
    logic [2:0]       W_stat_i;
    logic             imem_ready_i;
    logic             dmem_ready_i;

    logic             F_stall_o;
    logic             D_stall_o;
    logic             D_bubble_o;
    logic             E_stall_o;
    logic             E_bubble_o;
    logic             M_stall_o;
    logic             M_bubble_o;
    logic             W_stall_o;
    logic             W_bubble_o;
    logic             set_cc_o;
    logic [1:0]       cpu_state_o;
    logic             timeout_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] bubble_cnt_o;

    modport master (
        output D_icode_i, E_icode_i, M_icode_i, E_dstM_i, d_srcA_i, d_srcB_i,
               e_Cnd_i, m_stat_i, W_stat_i, imem_ready_i, dmem_ready_i,
        input  F_stall_o, D_stall_o, D_bubble_o, E_stall_o, E_bubble_o,
               M_stall_o, M_bubble_o, W_stall_o, W_bubble_o, set_cc_o,
               cpu_state_o, timeout_o, stall_cnt_o, bubble_cnt_o
    );

    modport slave (
        input  D_icode_i, E_icode_i, M_icode_i, E_dstM_i, d_srcA_i, d_srcB_i,
               e_Cnd_i, m_stat_i, W_stat_i, imem_ready_i, dmem_ready_i,
        output F_stall_o, D_stall_o, D_bubble_o, E_stall_o, E_bubble_o,
               M_stall_o, M_bubble_o, W_stall_o, W_bubble_o, set_cc_o,
               cpu_state_o, timeout_o, stall_cnt_o, bubble_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module : sat_counter
// Brief  : Event counter that holds at all-ones instead of wrapping.
// Rev    : 1.0
// ============================================================================
module sat_counter #(
    parameter int W = 32
) (
    input  wire logic         clk_i,
    input  wire logic         rst_n_i,
    input  wire logic         inc_i,
    output logic [W-1:0]      cnt_o
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt <= '0;
        end else if (inc_i && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign cnt_o = r_cnt;
endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module : pipe_hazard_ctrl
// Brief  : Y86-64 pipeline stall/bubble control, run/drain/halt FSM, dmem watchdog.
// Rev    : 1.0
// ============================================================================
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int WAIT_MAX = 255
) (
    input  wire logic          clk_i,
    input  wire logic          rst_n_i,
    pipe_hazard_ctrl_if.slave  bus
);
    localparam logic [15:0] c_WAIT_LAST = 16'(WAIT_MAX - 1);

    cpu_state_e  r_state;
    cpu_state_e  w_next_state;
    logic [15:0] r_wait_cnt;
    logic        r_timeout;

    logic w_mem_op, w_load_use, w_ret_in, w_mispred, w_m_exc, w_w_exc, w_dwait;
    logic w_timeout_set;

    logic w_n_fs, w_n_ds, w_n_db, w_n_eb, w_n_mb, w_n_ws, w_n_cc, w_n_any;

    logic w_fs, w_ds, w_db, w_es, w_eb, w_ms, w_mb, w_ws, w_wb, w_cc;
    logic w_any_stall, w_any_bubble;

    assign w_mem_op   = is_mem_op(bus.M_icode_i);
    assign w_load_use = ((bus.E_icode_i == IMRMOVQ) || (bus.E_icode_i == IPOPQ))
                      && (bus.E_dstM_i != RNONE)
                      && ((bus.E_dstM_i == bus.d_srcA_i) || (bus.E_dstM_i == bus.d_srcB_i));
    assign w_ret_in   = (bus.D_icode_i == IRET) || (bus.E_icode_i == IRET)
                      || (bus.M_icode_i == IRET);
    assign w_mispred  = (bus.E_icode_i == IJXX) && !bus.e_Cnd_i;
    assign w_m_exc    = (bus.m_stat_i != SAOK);
    assign w_w_exc    = (bus.W_stat_i != SAOK);
    assign w_dwait    = w_mem_op && !bus.dmem_ready_i;

    // Load-use wins over ret: D holds the decoding instruction rather than bubbling it.
    assign w_n_fs  = w_load_use | w_ret_in;
    assign w_n_ds  = w_load_use;
    assign w_n_db  = w_mispred | (w_ret_in & !w_load_use);
    assign w_n_eb  = w_mispred | w_load_use;
    assign w_n_mb  = w_m_exc | w_w_exc;
    assign w_n_ws  = w_w_exc;
    assign w_n_cc  = (bus.E_icode_i == IOPQ) & !w_m_exc & !w_w_exc;
    assign w_n_any = w_n_fs | w_n_ds | w_n_db | w_n_eb | w_n_mb | w_n_ws | w_n_cc;

    always_comb begin
        w_fs = 1'b0; w_ds = 1'b0; w_db = 1'b0; w_es = 1'b0; w_eb = 1'b0;
        w_ms = 1'b0; w_mb = 1'b0; w_ws = 1'b0; w_wb = 1'b0; w_cc = 1'b0;
        if (!rst_n_i) begin
            w_fs = 1'b0;
        end else if (r_state == CPU_HALT) begin
            w_fs = 1'b1; w_ds = 1'b1; w_es = 1'b1; w_ms = 1'b1; w_ws = 1'b1;
        end else if (w_dwait) begin
            w_fs = 1'b1; w_ds = 1'b1; w_es = 1'b1; w_ms = 1'b1; w_wb = 1'b1;
        end else if (w_n_any) begin
            w_fs = w_n_fs; w_ds = w_n_ds; w_db = w_n_db; w_eb = w_n_eb;
            w_mb = w_n_mb; w_ws = w_n_ws; w_cc = w_n_cc;
        end else if (!bus.imem_ready_i) begin
            w_fs = 1'b1; w_db = 1'b1;
        end
    end

    assign w_timeout_set = w_dwait && (r_wait_cnt == c_WAIT_LAST);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            CPU_RUN: begin
                if (w_w_exc) begin
                    w_next_state = CPU_HALT;
                end else if (w_m_exc && !w_dwait) begin
                    w_next_state = CPU_DRAIN;
                end
            end
            CPU_DRAIN: begin
                if (w_w_exc) begin
                    w_next_state = CPU_HALT;
                end
            end
            CPU_HALT: w_next_state = CPU_HALT;
            default:  w_next_state = CPU_RUN;
        endcase
        if (w_timeout_set) begin
            w_next_state = CPU_HALT;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= CPU_RUN;
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_timeout <= r_timeout | w_timeout_set;
            if (!w_dwait) begin
                r_wait_cnt <= '0;
            end else if (r_wait_cnt != 16'hFFFF) begin
                r_wait_cnt <= r_wait_cnt + 16'd1;
            end
        end
    end

    assign w_any_stall  = w_fs | w_ds | w_es | w_ms | w_ws;
    assign w_any_bubble = w_db | w_eb | w_mb | w_wb;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (w_any_stall),
        .cnt_o   (bus.stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (w_any_bubble),
        .cnt_o   (bus.bubble_cnt_o)
    );

    assign bus.F_stall_o   = w_fs;
    assign bus.D_stall_o   = w_ds;
    assign bus.D_bubble_o  = w_db;
    assign bus.E_stall_o   = w_es;
    assign bus.E_bubble_o  = w_eb;
    assign bus.M_stall_o   = w_ms;
    assign bus.M_bubble_o  = w_mb;
    assign bus.W_stall_o   = w_ws;
    assign bus.W_bubble_o  = w_wb;
    assign bus.set_cc_o    = w_cc;
    assign bus.cpu_state_o = r_state;
    assign bus.timeout_o   = r_timeout;
endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central pipeline control unit for the 5-stage Y86-64 core.
- Generates the stall and bubble controls for the F, D, E, M and W pipeline registers, including the decode→execute register.
- Detects the hazards: load-use, ret, mispredicted jXX, exception drain, and instruction/data memory wait states.
- Owns the core run/drain/halt state machine, a data-memory wait watchdog, and saturating stall/bubble performance counters.

Parameters:
- CNT_W, 32: width of the stall and bubble performance counters.
- WAIT_MAX, 255: maximum number of consecutive dmem wait cycles before a timeout is declared (valid range 1..65535).

Ports:
- clk_i  in  1  core clock.
- rst_n_i  in  1  reset; asynchronous assert, active-low.
- D_icode_i  in  4  icode held in the D register.
- E_icode_i  in  4  icode held in the E register.
- M_icode_i  in  4  icode held in the M register.
- E_dstM_i  in  4  dstM held in the E register.
- d_srcA_i  in  4  srcA of the instruction being decoded.
- d_srcB_i  in  4  srcB of the instruction being decoded.
- e_Cnd_i  in  1  branch condition computed in execute.
- m_stat_i  in  3  status produced by the memory stage.
- W_stat_i  in  3  status held in the W register.
- imem_ready_i  in  1  instruction fetch data valid this cycle.
- dmem_ready_i  in  1  data memory access completes this cycle.
- F_stall_o  out  1  stall the F register.
- D_stall_o  out  1  stall the D register.
- D_bubble_o  out  1  bubble the D register.
- E_stall_o  out  1  stall the E register.
- E_bubble_o  out  1  bubble the E register.
- M_stall_o  out  1  stall the M register.
- M_bubble_o  out  1  bubble the M register.
- W_stall_o  out  1  stall the W register.
- W_bubble_o  out  1  bubble the W register.
- set_cc_o  out  1  condition-code write enable.
- cpu_state_o  out  2  core state: 0=RUN, 1=DRAIN, 2=HALT.
- timeout_o  out  1  sticky dmem watchdog flag.
- stall_cnt_o  out  CNT_W  count of cycles with any stall asserted.
- bubble_cnt_o  out  CNT_W  count of cycles with any bubble asserted.

Behaviour:
- Reset: clock is clk_i; reset is rst_n_i, asynchronous and active-low.
  - On reset, the state goes to RUN, timeout_o=0, wait_cnt=0, and both counters are 0.
  - While rst_n_i is low, every stall, bubble and set_cc_o output is forced to 0.
- Hazard terms (all combinational):
  - mem_op = M_icode_i ∈ {IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ}.
  - load_use = E_icode_i ∈ {IMRMOVQ, IPOPQ} and E_dstM_i != RNONE and E_dstM_i ∈ {d_srcA_i, d_srcB_i}.
  - ret_in = IRET ∈ {D_icode_i, E_icode_i, M_icode_i}.
  - mispred = (E_icode_i == IJXX) and !e_Cnd_i.
  - m_exc = m_stat_i ∉ {SAOK}; w_exc = W_stat_i ∉ {SAOK}.
  - dwait = mem_op and !dmem_ready_i.
- Output priority (highest first); every output not named in a row is 0.
  1. HALT: F/D/E/M/W_stall=1.
  2. dwait: F/D/E/M_stall=1 and W_bubble=1.
  3. Normal hazard logic:
     - F_stall = load_use | ret_in.
     - D_stall = load_use.
     - D_bubble = mispred | (ret_in & !load_use).
     - E_bubble = mispred | load_use.
     - M_bubble = m_exc | w_exc.
     - W_stall = w_exc.
     - set_cc = (E_icode_i == IOPQ) & !m_exc & !w_exc.
  4. imem wait: applies when the rule-3 outputs are all 0 and !imem_ready_i; then F_stall=1 and D_bubble=1.
- FSM transitions, registered on clk_i:
  - RUN→DRAIN when m_exc and not dwait.
  - RUN→HALT directly when w_exc.
  - DRAIN→HALT when w_exc.
  - HALT is terminal; only reset leaves it.
  - The DRAIN outputs are identical to RUN; DRAIN only signals that the core is retiring up to the faulting instruction.
- Watchdog:
  - wait_cnt increments on each dwait cycle and clears on any non-dwait cycle.
  - If dwait holds and wait_cnt == WAIT_MAX-1, then on the next edge timeout_o goes to 1 and the state goes to HALT.
  - A dmem_ready_i arriving on that same cycle wins: no timeout is declared.
- Counters:
  - stall_cnt increments on each cycle where any *_stall_o is 1; bubble_cnt increments on each cycle where any *_bubble_o is 1.
  - Both saturate at all-ones and do not wrap. Both count in every state, including HALT, where stall_cnt keeps incrementing.
- Latency: the control outputs are combinational in the same cycle as their inputs; cpu_state_o, timeout_o and the counters update one edge later.
- Simultaneous events:
  - load_use with ret_in: load_use takes precedence (D stalled, not bubbled).
  - mispred with load_use cannot occur. If the inputs are forced that way, apply the formulas literally.

Decomposition:
- Shared package/define additions: CPU_RUN/CPU_DRAIN/CPU_HALT encodings.
- The existing icode, stat and RNONE defines are reused unchanged.
- One natural sub-module: sat_counter (parameter W; ports clk_i, rst_n_i, inc_i, cnt_o). It is instantiated twice, for the stall and bubble counters.

Test Plan:
- Load-use: E_icode=IMRMOVQ, E_dstM=3, d_srcA=3 → F_stall=1, D_stall=1, E_bubble=1 for 1 cycle; stall_cnt 0→1 and bubble_cnt 0→1.
- Ret: D_icode=IRET, then E, then M on 3 consecutive cycles → F_stall=1 and D_bubble=1 on each of the 3 cycles; D_stall=0 throughout.
- Mispredict: E_icode=IJXX, e_Cnd=0 → D_bubble=1, E_bubble=1, F_stall=0.
- Exception: m_stat=SADR → M_bubble=1 and next state DRAIN; then W_stat=SADR → W_stall=1 and state HALT; thereafter all five stalls stay at 1 until rst_n_i=0.
- Dmem wait, WAIT_MAX=4:
  - M_icode=IMRMOVQ with dmem_ready=0 for 3 cycles, then 1 → F/D/E/M_stall=1 and W_bubble=1 for 3 cycles, with no timeout.
  - The same stimulus held for 4 cycles → timeout_o=1 and cpu_state=HALT.
- Async reset mid-HALT with CNT_W=4 and counters saturated at 15 → all outputs go to 0 immediately, without waiting for a clock edge; state returns to RUN.
